// File: rtl/sampler_pkg.sv
// Shared types and defaults for the rejection sampler controller and its filter.
package sampler_pkg;
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_TEST  = 3'd2,
    ST_EMIT  = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

  localparam int DEF_BASE_LIMIT   = 200;
  localparam int DEF_SHIFT_FACTOR = 4;
  localparam int REJ_CNT_W        = 16;
endpackage

// File: rtl/rejection_filter.sv
// Accepts a (magnitude, random word) pair when rnd < BASE_LIMIT - (mag << SHIFT_FACTOR),
// with the limit floored at zero so large magnitudes are always rejected.
module rejection_filter
  import sampler_pkg::*;
#(
  parameter int VALUE_WIDTH  = 4,
  parameter int RAND_WIDTH   = 8,
  parameter int BASE_LIMIT   = DEF_BASE_LIMIT,
  parameter int SHIFT_FACTOR = DEF_SHIFT_FACTOR
) (
  input  logic [VALUE_WIDTH-1:0] mag_i,
  input  logic [RAND_WIDTH-1:0]  rnd_i,
  output logic                   accept_o
);
  logic [31:0] scaled;
  logic [31:0] limit;

  always_comb begin
    scaled   = 32'(mag_i) << SHIFT_FACTOR;
    limit    = (scaled >= 32'(BASE_LIMIT)) ? 32'd0 : 32'(BASE_LIMIT) - scaled;
    accept_o = 32'(rnd_i) < limit;
  end
endmodule

// File: rtl/rejection_sampler_ctrl.sv
// Pairs candidates with random words, filters them, and streams NUM_COEFFS accepted samples.
// state | meaning: IDLE wait start | FETCH capture pair | TEST filter | EMIT present sample | DONE pulse
module rejection_sampler_ctrl
  import sampler_pkg::*;
#(
  parameter int VALUE_WIDTH  = 4,
  parameter int RAND_WIDTH   = 8,
  parameter int BASE_LIMIT   = DEF_BASE_LIMIT,
  parameter int SHIFT_FACTOR = DEF_SHIFT_FACTOR,
  parameter int NUM_COEFFS   = 256,
  parameter int MAX_RETRY    = 64
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic                   cand_valid,
  output logic                   cand_ready,
  input  logic                   cand_sign,
  input  logic [VALUE_WIDTH-1:0] cand_mag,
  input  logic                   rnd_valid,
  output logic                   rnd_ready,
  input  logic [RAND_WIDTH-1:0]  rnd_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [VALUE_WIDTH:0]   out_data,
  output logic                   out_last,
  output logic                   busy,
  output logic                   done,
  output logic                   err_abort,
  output logic [REJ_CNT_W-1:0]   reject_cnt
);
  localparam int ACC_W = $clog2(NUM_COEFFS + 1);
  localparam int RTY_W = $clog2(MAX_RETRY + 1);
  localparam logic [ACC_W-1:0] LAST_IDX = ACC_W'(NUM_COEFFS - 1);

  state_e                   state_q, state_d;
  logic                     cand_held_q, cand_held_d, rnd_held_q, rnd_held_d;
  logic                     cand_sign_q, cand_sign_d;
  logic [VALUE_WIDTH-1:0]   cand_mag_q, cand_mag_d;
  logic [RAND_WIDTH-1:0]    rnd_q, rnd_d;
  logic [ACC_W-1:0]         acc_cnt_q, acc_cnt_d;
  logic [RTY_W-1:0]         retry_cnt_q, retry_cnt_d, retry_inc;
  logic [REJ_CNT_W-1:0]     reject_cnt_q, reject_cnt_d;
  logic                     err_abort_q, err_abort_d;
  logic [VALUE_WIDTH:0]     out_data_q, out_data_d;
  logic                     cand_ready_q, cand_ready_d, rnd_ready_q, rnd_ready_d;
  logic                     out_valid_q, out_valid_d, out_last_q, out_last_d;
  logic                     busy_q, busy_d, done_q, done_d;
  logic                     accept;

  rejection_filter #(
    .VALUE_WIDTH (VALUE_WIDTH),
    .RAND_WIDTH  (RAND_WIDTH),
    .BASE_LIMIT  (BASE_LIMIT),
    .SHIFT_FACTOR(SHIFT_FACTOR)
  ) u_filter (
    .mag_i   (cand_mag_q),
    .rnd_i   (rnd_q),
    .accept_o(accept)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      cand_held_q  <= 1'b0;
      rnd_held_q   <= 1'b0;
      cand_sign_q  <= 1'b0;
      cand_mag_q   <= '0;
      rnd_q        <= '0;
      acc_cnt_q    <= '0;
      retry_cnt_q  <= '0;
      reject_cnt_q <= '0;
      err_abort_q  <= 1'b0;
      out_data_q   <= '0;
      cand_ready_q <= 1'b0;
      rnd_ready_q  <= 1'b0;
      out_valid_q  <= 1'b0;
      out_last_q   <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cand_held_q  <= cand_held_d;
      rnd_held_q   <= rnd_held_d;
      cand_sign_q  <= cand_sign_d;
      cand_mag_q   <= cand_mag_d;
      rnd_q        <= rnd_d;
      acc_cnt_q    <= acc_cnt_d;
      retry_cnt_q  <= retry_cnt_d;
      reject_cnt_q <= reject_cnt_d;
      err_abort_q  <= err_abort_d;
      out_data_q   <= out_data_d;
      cand_ready_q <= cand_ready_d;
      rnd_ready_q  <= rnd_ready_d;
      out_valid_q  <= out_valid_d;
      out_last_q   <= out_last_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    cand_held_d  = cand_held_q;
    rnd_held_d   = rnd_held_q;
    cand_sign_d  = cand_sign_q;
    cand_mag_d   = cand_mag_q;
    rnd_d        = rnd_q;
    acc_cnt_d    = acc_cnt_q;
    retry_cnt_d  = retry_cnt_q;
    reject_cnt_d = reject_cnt_q;
    err_abort_d  = err_abort_q;
    out_data_d   = out_data_q;
    retry_inc    = retry_cnt_q + RTY_W'(1);
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          acc_cnt_d    = '0;
          retry_cnt_d  = '0;
          reject_cnt_d = '0;
          err_abort_d  = 1'b0;
          cand_held_d  = 1'b0;
          rnd_held_d   = 1'b0;
          state_d      = ST_FETCH;
        end
      end
      ST_FETCH: begin
        if (cand_valid && cand_ready_q) begin
          cand_sign_d = cand_sign;
          cand_mag_d  = cand_mag;
          cand_held_d = 1'b1;
        end
        if (rnd_valid && rnd_ready_q) begin
          rnd_d      = rnd_data;
          rnd_held_d = 1'b1;
        end
        if (cand_held_d && rnd_held_d) state_d = ST_TEST;
      end
      ST_TEST: begin
        cand_held_d = 1'b0;
        rnd_held_d  = 1'b0;
        if (accept) begin
          out_data_d = {cand_sign_q, cand_mag_q};
          state_d    = ST_EMIT;
        end else begin
          if (reject_cnt_q != '1) reject_cnt_d = reject_cnt_q + REJ_CNT_W'(1);
          retry_cnt_d = retry_inc;
          if (retry_inc == RTY_W'(MAX_RETRY)) begin
            err_abort_d = 1'b1;
            state_d     = ST_DONE;
          end else begin
            state_d = ST_FETCH;
          end
        end
      end
      ST_EMIT: begin
        if (out_valid_q && out_ready) begin
          acc_cnt_d   = acc_cnt_q + ACC_W'(1);
          retry_cnt_d = '0;
          state_d     = out_last_q ? ST_DONE : ST_FETCH;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs are decoded from next state so each lands in a flop aligned with its state.
  always_comb begin
    cand_ready_d = (state_d == ST_FETCH) && !cand_held_d;
    rnd_ready_d  = (state_d == ST_FETCH) && !rnd_held_d;
    out_valid_d  = (state_d == ST_EMIT);
    out_last_d   = (state_d == ST_EMIT) && (acc_cnt_d == LAST_IDX);
    busy_d       = (state_d != ST_IDLE);
    done_d       = (state_d == ST_DONE);
  end

  assign cand_ready = cand_ready_q;
  assign rnd_ready  = rnd_ready_q;
  assign out_valid  = out_valid_q;
  assign out_data   = out_data_q;
  assign out_last   = out_last_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign err_abort  = err_abort_q;
  assign reject_cnt = reject_cnt_q;
endmodule

// File: tb/tb_rejection_sampler_ctrl.sv
// Directed and randomized blocks checked against a pair-by-pair acceptance model.
module tb_rejection_sampler_ctrl;
  localparam int NC = 4;
  localparam int MR = 3;

  logic       clk = 1'b0, rst_n = 1'b1, start = 1'b0;
  logic       cand_valid = 1'b0, cand_sign = 1'b0, rnd_valid = 1'b0, out_ready = 1'b0;
  logic [3:0] cand_mag = '0;
  logic [7:0] rnd_data = '0;
  logic       cand_ready, rnd_ready, out_valid, out_last, busy, done, err_abort;
  logic [4:0] out_data;
  logic [15:0] reject_cnt;

  int total = 0, bad = 0;

  logic [4:0] p_c[$], cq[$], exp_q[$], obs_data[$];
  logic [7:0] p_r[$], rq[$];
  bit         obs_last[$];
  int         obs_cyc[$];
  int         exp_rej, exp_used, done_cnt, done_cyc, c_hs_cyc, r_hs_cyc;
  bit         exp_ab;

  rejection_sampler_ctrl #(
    .VALUE_WIDTH(4), .RAND_WIDTH(8), .BASE_LIMIT(200), .SHIFT_FACTOR(4),
    .NUM_COEFFS(NC), .MAX_RETRY(MR)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .cand_valid(cand_valid), .cand_ready(cand_ready), .cand_sign(cand_sign), .cand_mag(cand_mag),
    .rnd_valid(rnd_valid), .rnd_ready(rnd_ready), .rnd_data(rnd_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
    .busy(busy), .done(done), .err_abort(err_abort), .reject_cnt(reject_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic add_pair(input bit s, input int mag, input int rnd);
    p_c.push_back({s, 4'(mag)});
    p_r.push_back(8'(rnd));
  endtask

  task automatic gen_pairs(input int n, input int maxmag);
    p_c.delete();
    p_r.delete();
    for (int i = 0; i < n; i++)
      add_pair(1'($urandom_range(0, 1)), $urandom_range(0, maxmag), $urandom_range(0, 255));
  endtask

  // Walk the pairs in arrival order: accept when rnd < max(0, 200 - 16*mag).
  task automatic model();
    int consec, lim;
    exp_q.delete();
    exp_rej = 0; exp_ab = 0; exp_used = 0; consec = 0;
    for (int i = 0; i < p_c.size() && !exp_ab && exp_q.size() < NC; i++) begin
      exp_used++;
      lim = 200 - 16 * int'(p_c[i][3:0]);
      if (lim < 0) lim = 0;
      if (int'(p_r[i]) < lim) begin
        exp_q.push_back(p_c[i]);
        consec = 0;
      end else begin
        exp_rej++;
        consec++;
        if (consec == MR) exp_ab = 1;
      end
    end
  endtask

  task automatic run_block(input int cpct, input int rpct, input int opct,
                           input int rdelay, input int stall);
    int cyc, stall_left;
    bit hc, hr, ho, prev_stall;
    model();
    cq = p_c; rq = p_r;
    obs_data.delete(); obs_last.delete(); obs_cyc.delete();
    done_cnt = 0; done_cyc = -1; c_hs_cyc = -1; r_hs_cyc = -1;
    stall_left = stall; prev_stall = 0;
    cand_valid = 1; rnd_valid = 1; out_ready = 1;
    chk("idle_ready", {cand_ready, rnd_ready}, 0);
    tick();
    chk("idle_busy", busy, 0);
    cand_valid = 0; rnd_valid = 0; start = 1;
    tick();
    start = 0;
    chk("start_busy", busy, 1);
    chk("start_clr_abort", err_abort, 0);
    chk("start_clr_rej", reject_cnt, 0);
    cyc = 0;
    while (cyc < 800 && done_cnt == 0) begin
      cand_valid = (cq.size() > 0) && ($urandom_range(0, 99) < cpct);
      {cand_sign, cand_mag} = (cq.size() > 0) ? cq[0] : 5'd0;
      rnd_valid = (rq.size() > 0) && (cyc >= rdelay) && ($urandom_range(0, 99) < rpct);
      rnd_data = (rq.size() > 0) ? rq[0] : 8'd0;
      if (out_valid && stall_left > 0) begin
        out_ready = 0;
        stall_left--;
      end else begin
        out_ready = $urandom_range(0, 99) < opct;
      end
      if (out_valid) chk("emit_no_take", {cand_ready, rnd_ready}, 0);
      if (out_valid && obs_data.size() < exp_q.size())
        chk("emit_data", out_data, exp_q[obs_data.size()]);
      else if (out_valid)
        chk("extra_valid", out_valid, 0);
      if (prev_stall) chk("stall_valid", out_valid, 1);
      if (c_hs_cyc >= 0 && r_hs_cyc < 0 && cyc > c_hs_cyc) chk("held_no_cand", cand_ready, 0);
      hc = cand_valid && cand_ready;
      hr = rnd_valid && rnd_ready;
      ho = out_valid && out_ready;
      if (hc && c_hs_cyc < 0) c_hs_cyc = cyc;
      if (hr && r_hs_cyc < 0) r_hs_cyc = cyc;
      if (ho) begin
        obs_data.push_back(out_data);
        obs_last.push_back(out_last);
        obs_cyc.push_back(cyc);
      end
      prev_stall = out_valid && !out_ready;
      tick();
      cyc++;
      if (hc) void'(cq.pop_front());
      if (hr) void'(rq.pop_front());
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
    end
    cand_valid = 0; rnd_valid = 0; out_ready = 0;
    chk("block_done", done_cnt, 1);
  endtask

  task automatic check_block(input string tag);
    chk({tag, "_count"}, obs_data.size(), exp_q.size());
    for (int i = 0; i < obs_data.size() && i < exp_q.size(); i++) begin
      chk({tag, "_data"}, obs_data[i], exp_q[i]);
      chk({tag, "_last"}, obs_last[i], (i == NC - 1));
    end
    chk({tag, "_rej"}, reject_cnt, exp_rej);
    chk({tag, "_abort"}, err_abort, exp_ab);
    chk({tag, "_cons_c"}, p_c.size() - cq.size(), exp_used);
    chk({tag, "_cons_r"}, p_r.size() - rq.size(), exp_used);
    if (obs_cyc.size() == NC) chk({tag, "_done_lat"}, done_cyc, obs_cyc[NC-1] + 1);
    tick();
    chk({tag, "_done_pulse"}, {done, busy}, 0);
  endtask

  initial begin
    #1 rst_n = 0;
    #20;
    chk("reset_outs", {cand_ready, rnd_ready, out_valid, out_data, out_last, busy, done,
                       err_abort, reject_cnt}, 0);
    @(posedge clk);
    #1 rst_n = 1;
    tick();

    // 1: steady stream, every pair accepted
    p_c.delete(); p_r.delete();
    repeat (NC) add_pair(0, 0, 199);
    run_block(100, 100, 100, 0, 0);
    check_block("t1");
    for (int i = 0; i < obs_cyc.size(); i++) chk("t1_cadence", obs_cyc[i], 2 + 3 * i);
    chk("t1_done_cyc", done_cyc, 12);
    chk("t1_rej", reject_cnt, 0);

    // 2: acceptance limit boundaries
    p_c.delete(); p_r.delete();
    add_pair(0, 12, 7); add_pair(1, 12, 8); add_pair(0, 0, 200);
    add_pair(1, 0, 199); add_pair(0, 5, 50); add_pair(1, 3, 10);
    run_block(100, 100, 100, 0, 0);
    check_block("t2");
    chk("t2_first", obs_data.size() > 0 ? obs_data[0] : 5'bx, 5'h0C);
    chk("t2_rej", reject_cnt, 2);

    // 3: zero limit, abort after MR consecutive rejections
    p_c.delete(); p_r.delete();
    add_pair(0, 13, 0); add_pair(1, 15, 0); add_pair(0, 13, 0); add_pair(0, 0, 0);
    run_block(100, 100, 100, 0, 0);
    check_block("t3");
    chk("t3_abort", err_abort, 1);
    chk("t3_rej", reject_cnt, 3);
    chk("t3_nout", obs_data.size(), 0);

    // 4: downstream stall of 10 cycles on first sample
    p_c.delete(); p_r.delete();
    add_pair(0, 2, 0); add_pair(1, 7, 1); add_pair(0, 1, 3); add_pair(1, 0, 9);
    run_block(100, 100, 100, 0, 10);
    check_block("t4");
    chk("t4_first_hs", obs_cyc.size() > 0 ? obs_cyc[0] : -1, 12);

    // 5: random word arrives 5 cycles late
    p_c.delete(); p_r.delete();
    repeat (NC) add_pair(1, 1, 5);
    run_block(100, 100, 100, 5, 0);
    check_block("t5");
    chk("t5_cand_hs", c_hs_cyc, 0);
    chk("t5_rnd_hs", r_hs_cyc, 5);
    chk("t5_emit", obs_cyc.size() > 0 ? obs_cyc[0] : -1, 7);

    // 6: reset during second sample, then a clean block
    start = 1;
    tick();
    start = 0;
    cand_valid = 1; cand_sign = 0; cand_mag = 0; rnd_valid = 1; rnd_data = 0; out_ready = 1;
    repeat (4) tick();
    chk("t6_busy_before", busy, 1);
    #2 rst_n = 0;
    #1;
    chk("t6_async_clear", {cand_ready, rnd_ready, out_valid, out_data, out_last, busy, done,
                           err_abort, reject_cnt}, 0);
    tick();
    tick();
    rst_n = 1;
    cand_valid = 0; rnd_valid = 0;
    repeat (3) begin
      tick();
      chk("t6_no_done", {done, busy}, 0);
    end
    p_c.delete(); p_r.delete();
    add_pair(1, 4, 100); add_pair(0, 9, 60); add_pair(0, 9, 40);
    add_pair(1, 6, 20); add_pair(0, 2, 150);
    run_block(100, 100, 100, 0, 0);
    check_block("t6");

    // randomized blocks with random source/sink gaps
    for (int b = 0; b < 10; b++) begin
      gen_pairs(20, (b % 2) ? 15 : 6);
      run_block($urandom_range(40, 100), $urandom_range(40, 100), $urandom_range(40, 100),
                $urandom_range(0, 3), $urandom_range(0, 4));
      check_block("rnd");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
